alu_exec_unit: RTL and testbench

- Execute-stage block of the single-cycle MIPS datapath.
- Decodes the ALU operation from ALUOp and funct, and computes the 32-bit ALU result and zero flag.
- Computes PC+4 and the branch target with two independent adders.
- Holds a registered copy of the last result and its N/Z/V status flags, which the jump/branch controller consumes.

---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu_core.sv | 49 ++++
 rtl/alu_exec_unit.sv | 81 ++++++++
 tb/tb_alu_exec_unit.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the execute stage: ALU control codes, ALUOp values
// from main control, and the R-type funct field values the decoder recognises.
package alu_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;  // loads/stores
  localparam logic [1:0] ALUOP_SUB   = 2'b01;  // beq
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;  // decode funct
  localparam logic [1:0] ALUOP_OR    = 2'b11;  // ori

  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: operation select on the decoded control, plus the zero
// and signed-overflow indications for the flag registers in the parent.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       alu_ctl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow
);

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             slt;

  assign sum  = a + b;
  assign diff = a - b;
  // Signed compare on the operands, not on diff, so it survives overflow.
  assign slt  = ($signed(a) < $signed(b));

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    result = '0;
    case (alu_ctl)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_ADD: result = sum;
      ALU_SUB: result = diff;
      ALU_SLT: result = {{(WIDTH-1){1'b0}}, slt};
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

  always_comb begin
    overflow = 1'b0;
    case (alu_ctl)
      ALU_ADD: overflow = (a[WIDTH-1] == b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
      ALU_SUB: overflow = (a[WIDTH-1] != b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
      default: overflow = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute stage of the single-cycle MIPS datapath: ALU control decode, ALU,
// PC+4 / branch-target adders and the registered result/status flags.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int PC_INC = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       aluop,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] sext_off,
  input  logic             flag_we,
  output logic [2:0]       alu_ctl,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic [WIDTH-1:0] pc_plus4,
  output logic [WIDTH-1:0] br_target,
  output logic [WIDTH-1:0] prev_result,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_v
);

  localparam logic [WIDTH-1:0] PC_INC_W = WIDTH'(PC_INC);

  logic overflow;

  always_comb begin
    alu_ctl = ALU_ADD;
    case (aluop)
      ALUOP_ADD: alu_ctl = ALU_ADD;
      ALUOP_SUB: alu_ctl = ALU_SUB;
      ALUOP_OR:  alu_ctl = ALU_OR;
      default: begin
        // Unknown funct codes fall back to ADD so the control is never X.
        case (funct)
          FUNCT_ADD: alu_ctl = ALU_ADD;
          FUNCT_SUB: alu_ctl = ALU_SUB;
          FUNCT_AND: alu_ctl = ALU_AND;
          FUNCT_OR:  alu_ctl = ALU_OR;
          FUNCT_SLT: alu_ctl = ALU_SLT;
          default:   alu_ctl = ALU_ADD;
        endcase
      end
    endcase
  end

  alu_core #(.WIDTH(WIDTH)) u_core (
    .alu_ctl  (alu_ctl),
    .a        (a),
    .b        (b),
    .result   (result),
    .zero     (zero),
    .overflow (overflow)
  );

  // Adders depend only on pc and sext_off, never on ALU inputs.
  assign pc_plus4  = pc + PC_INC_W;
  assign br_target = pc_plus4 + sext_off;

  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments so all flags update from the same pre-edge values.
    if (!rst_n) begin
      prev_result <= '0;
      flag_n      <= 1'b0;
      flag_z      <= 1'b0;
      flag_v      <= 1'b0;
    end else if (flag_we) begin
      prev_result <= result;
      flag_n      <= result[WIDTH-1];
      flag_z      <= zero;
      flag_v      <= overflow;
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed corner cases followed by
// randomized transactions compared against an arithmetic reference model.
module tb_alu_exec_unit;

  logic        clk;
  logic        rst_n;
  logic [1:0]  aluop;
  logic [5:0]  funct;
  logic [31:0] a, b, pc, sext_off;
  logic        flag_we;
  logic [2:0]  alu_ctl;
  logic [31:0] result, pc_plus4, br_target, prev_result;
  logic        zero, flag_n, flag_z, flag_v;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference register state
  logic [31:0] m_prev;
  logic        m_n, m_z, m_v;

  alu_exec_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .aluop       (aluop),
    .funct       (funct),
    .a           (a),
    .b           (b),
    .pc          (pc),
    .sext_off    (sext_off),
    .flag_we     (flag_we),
    .alu_ctl     (alu_ctl),
    .result      (result),
    .zero        (zero),
    .pc_plus4    (pc_plus4),
    .br_target   (br_target),
    .prev_result (prev_result),
    .flag_n      (flag_n),
    .flag_z      (flag_z),
    .flag_v      (flag_v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] exp_ctl(input logic [1:0] op, input logic [5:0] fn);
    if (op == 2'b00) return 3'b010;
    if (op == 2'b01) return 3'b110;
    if (op == 2'b11) return 3'b001;
    if (fn == 6'h22) return 3'b110;
    if (fn == 6'h24) return 3'b000;
    if (fn == 6'h25) return 3'b001;
    if (fn == 6'h2A) return 3'b111;
    return 3'b010;
  endfunction

  // Overflow is judged by whether the exact signed answer fits in 32 bits.
  task automatic alu_model(input logic [2:0] ctl, input logic [31:0] x, input logic [31:0] y,
                           output logic [31:0] r, output logic v);
    longint sx, sy, s;
    sx = $signed(x);
    sy = $signed(y);
    v  = 1'b0;
    r  = 32'h0;
    case (ctl)
      3'b000: r = x & y;
      3'b001: r = x | y;
      3'b010: begin
        s = sx + sy;
        r = s[31:0];
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      3'b110: begin
        s = sx - sy;
        r = s[31:0];
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      3'b111: r = (sx < sy) ? 32'd1 : 32'd0;
      default: r = 32'h0;
    endcase
  endtask

  task automatic step(input string tag, input logic [1:0] op, input logic [5:0] fn,
                      input logic [31:0] x, input logic [31:0] y,
                      input logic [31:0] p, input logic [31:0] off,
                      input logic we, input logic rn);
    logic [2:0]  ec;
    logic [31:0] er;
    logic        ev;
    aluop = op; funct = fn; a = x; b = y; pc = p; sext_off = off;
    flag_we = we; rst_n = rn;
    #2;
    ec = exp_ctl(op, fn);
    alu_model(ec, x, y, er, ev);
    check({tag, ".alu_ctl"},   {29'h0, alu_ctl}, {29'h0, ec});
    check({tag, ".result"},    result, er);
    check({tag, ".zero"},      {31'h0, zero}, {31'h0, er == 32'h0});
    check({tag, ".pc_plus4"},  pc_plus4, p + 32'd4);
    check({tag, ".br_target"}, br_target, p + 32'd4 + off);
    @(posedge clk);
    if (!rn) begin
      m_prev = '0; m_n = 1'b0; m_z = 1'b0; m_v = 1'b0;
    end else if (we) begin
      m_prev = er; m_n = er[31]; m_z = (er == 32'h0); m_v = ev;
    end
    #1;
    check({tag, ".prev_result"}, prev_result, m_prev);
    check({tag, ".flag_n"}, {31'h0, flag_n}, {31'h0, m_n});
    check({tag, ".flag_z"}, {31'h0, flag_z}, {31'h0, m_z});
    check({tag, ".flag_v"}, {31'h0, flag_v}, {31'h0, m_v});
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0: return 32'h7FFF_FFFF;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 3));
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [5:0] rand_funct();
    logic [5:0] codes [5];
    codes = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    if ($urandom_range(0, 3) == 0) return 6'($urandom);
    return codes[$urandom_range(0, 4)];
  endfunction

  initial begin
    m_prev = '0; m_n = 1'b0; m_z = 1'b0; m_v = 1'b0;
    aluop = '0; funct = '0; a = '0; b = '0; pc = '0; sext_off = '0;
    flag_we = 1'b0; rst_n = 1'b0;
    #1;

    step("reset", 2'b00, 6'h00, 32'h5, 32'h6, 32'h0, 32'h0, 1'b1, 1'b0);

    // Decode sweep
    step("dec00",   2'b00, 6'h2A, 32'h10, 32'h3, 32'h100, 32'h8, 1'b0, 1'b1);
    step("dec01",   2'b01, 6'h20, 32'h10, 32'h3, 32'h100, 32'h8, 1'b0, 1'b1);
    step("dec11",   2'b11, 6'h24, 32'hF0, 32'h0F, 32'h100, 32'h8, 1'b0, 1'b1);
    step("dec_slt", 2'b10, 6'h2A, 32'h3, 32'h10, 32'h100, 32'h8, 1'b0, 1'b1);
    step("dec_3f",  2'b10, 6'h3F, 32'h3, 32'h10, 32'h100, 32'h8, 1'b0, 1'b1);
    step("dec_and", 2'b10, 6'h24, 32'hFF00FF00, 32'h0FF00FF0, 32'h0, 32'h0, 1'b0, 1'b1);

    // Overflow, zero and hold behaviour
    step("add_ovf", 2'b10, 6'h20, 32'h7FFF_FFFF, 32'h1, 32'h0, 32'h0, 1'b1, 1'b1);
    check("add_ovf.n_set", {31'h0, flag_n}, 32'h1);
    check("add_ovf.v_set", {31'h0, flag_v}, 32'h1);
    step("sub_zero", 2'b10, 6'h22, 32'h1234_5678, 32'h1234_5678, 32'h0, 32'h0, 1'b1, 1'b1);
    check("sub_zero.z_set", {31'h0, flag_z}, 32'h1);
    step("hold", 2'b10, 6'h20, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h4, 32'h4, 1'b0, 1'b1);
    step("sub_ovf", 2'b01, 6'h00, 32'h8000_0000, 32'h1, 32'h0, 32'h0, 1'b1, 1'b1);

    // Signed compare
    step("slt_neg", 2'b10, 6'h2A, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0, 1'b1, 1'b1);
    step("slt_swap", 2'b10, 6'h2A, 32'h1, 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b1, 1'b1);
    step("slt_ovf", 2'b10, 6'h2A, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0, 32'h0, 1'b1, 1'b1);

    // Adder wrap
    step("pc_wrap", 2'b00, 6'h00, 32'h0, 32'h0, 32'hFFFF_FFFC, 32'h10, 1'b0, 1'b1);
    step("br_back", 2'b00, 6'h00, 32'h0, 32'h0, 32'h20, 32'hFFFF_FFF8, 1'b0, 1'b1);

    // Load nonzero state, then reset with flag_we high
    step("preload", 2'b10, 6'h20, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h0, 32'h0, 1'b1, 1'b1);
    step("rst_we",  2'b10, 6'h25, 32'hA5A5_0000, 32'h0000_5A5A, 32'h40, 32'h4, 1'b1, 1'b0);

    for (int i = 0; i < 400; i++) begin
      step("rand", 2'($urandom), rand_funct(), rand_operand(), rand_operand(),
           $urandom, $urandom, 1'($urandom), ($urandom_range(0, 19) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
